// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types: completion buffer depth, index type and entry layout.
package rv32i_types_pkg;

  localparam int NUM_CB_ENTRY = 16;
  localparam int CB_IDX_W     = $clog2(NUM_CB_ENTRY);
  localparam int NUM_FU_PORTS = 4;

  typedef logic [CB_IDX_W-1:0] cb_index_t;

  typedef enum logic [1:0] {
    FU_ARITH     = 2'd0,
    FU_MUL       = 2'd1,
    FU_DIV       = 2'd2,
    FU_LOADSTORE = 2'd3
  } fu_port_e;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic        exception;
  } cb_entry_t;

endpackage

// File: rtl/completion_buffer_if.sv
// Bundle of allocation, writeback, commit and status signals of the completion buffer.
interface completion_buffer_if
  import rv32i_types_pkg::*;
#(
  parameter int NUM_ENTRY = NUM_CB_ENTRY,
  parameter int NUM_FU    = NUM_FU_PORTS,
  parameter int IDX_W     = $clog2(NUM_ENTRY)
);

  logic                             alloc_req;
  logic [4:0]                       alloc_rd;
  logic                             alloc_wen;
  logic                             alloc_ready;
  logic [IDX_W-1:0]                 alloc_index;

  logic [NUM_FU-1:0]                wb_valid;
  logic [NUM_FU-1:0][IDX_W-1:0]     wb_index;
  logic [NUM_FU-1:0][31:0]          wb_data;
  logic [NUM_FU-1:0]                wb_exception;

  logic                             commit_valid;
  logic [4:0]                       commit_rd;
  logic                             commit_wen;
  logic [31:0]                      commit_data;
  logic                             commit_exception;

  logic                             flush;
  logic                             full;
  logic                             empty;
  logic [IDX_W:0]                   count;

  // Pipeline side: decode, functional units and the flush controller.
  modport master (
    output alloc_req, alloc_rd, alloc_wen,
    output wb_valid, wb_index, wb_data, wb_exception,
    output flush,
    input  alloc_ready, alloc_index,
    input  commit_valid, commit_rd, commit_wen, commit_data, commit_exception,
    input  full, empty, count
  );

  modport slave (
    input  alloc_req, alloc_rd, alloc_wen,
    input  wb_valid, wb_index, wb_data, wb_exception,
    input  flush,
    output alloc_ready, alloc_index,
    output commit_valid, commit_rd, commit_wen, commit_data, commit_exception,
    output full, empty, count
  );

endinterface

// File: rtl/completion_buffer.sv
// In-order completion buffer: entries allocated at the tail, completed out of order
// by the functional units, and retired one per cycle from the head.
module completion_buffer
  import rv32i_types_pkg::*;
#(
  parameter int NUM_ENTRY = NUM_CB_ENTRY,
  parameter int NUM_FU    = NUM_FU_PORTS,
  parameter int IDX_W     = $clog2(NUM_ENTRY)
) (
  input  logic              CLK,
  input  logic              nRST,
  completion_buffer_if.slave cb
);

  localparam int PTR_W = IDX_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  cb_entry_t         entries_q [NUM_ENTRY];
  cb_entry_t         entries_d [NUM_ENTRY];
  ptr_t              head_q, head_d;
  ptr_t              tail_q, tail_d;
  ptr_t              count_q, count_d;

  idx_t              head_idx;
  idx_t              tail_idx;
  cb_entry_t         head_entry;
  logic              full;
  logic              empty;
  logic              alloc_fire;
  logic              commit_fire;
  logic [NUM_FU-1:0] wb_hit;

  assign head_idx   = head_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];
  assign head_entry = entries_q[head_idx];

  // The pointer MSB is a wrap bit: equal indices mean full only when the laps differ.
  assign full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty = (head_q == tail_q);

  assign alloc_fire  = cb.alloc_req && cb.alloc_ready;
  assign commit_fire = head_entry.valid && head_entry.done && !cb.flush;

  assign cb.alloc_ready      = !full && !cb.flush;
  assign cb.alloc_index      = tail_idx;
  assign cb.commit_valid     = commit_fire;
  assign cb.commit_rd        = head_entry.rd;
  assign cb.commit_wen       = head_entry.wen;
  assign cb.commit_data      = head_entry.data;
  assign cb.commit_exception = head_entry.exception;
  assign cb.full             = full;
  assign cb.empty            = empty;
  assign cb.count            = count_q;

  // A writeback only lands on an entry that is allocated and still waiting for its result.
  generate
    for (genvar g = 0; g < NUM_FU; g++) begin : g_wb
      assign wb_hit[g] = cb.wb_valid[g]
                      && entries_q[cb.wb_index[g]].valid
                      && !entries_q[cb.wb_index[g]].done;
    end
  endgenerate

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    // Walk from the highest port down so the lowest-numbered port overwrites last.
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (wb_hit[i]) begin
        entries_d[cb.wb_index[i]].done      = 1'b1;
        entries_d[cb.wb_index[i]].data      = cb.wb_data[i];
        entries_d[cb.wb_index[i]].exception = cb.wb_exception[i];
      end
    end

    if (commit_fire) begin
      entries_d[head_idx] = '0;
      head_d              = head_q + ptr_t'(1);
    end

    if (alloc_fire) begin
      entries_d[tail_idx].valid     = 1'b1;
      entries_d[tail_idx].done      = 1'b0;
      entries_d[tail_idx].rd        = cb.alloc_rd;
      entries_d[tail_idx].wen       = cb.alloc_wen;
      entries_d[tail_idx].data      = '0;
      entries_d[tail_idx].exception = 1'b0;
      tail_d                        = tail_q + ptr_t'(1);
    end

    count_d = count_q + ptr_t'(alloc_fire) - ptr_t'(commit_fire);

    if (cb.flush) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        entries_d[e] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        entries_q[e] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_completion_buffer.sv
// Directed bench for completion_buffer: fill/wrap, out-of-order completion, port priority,
// full-buffer commit/alloc interplay, flush and asynchronous reset.
module tb_completion_buffer;
  import rv32i_types_pkg::*;

  localparam int NUM_ENTRY = 16;
  localparam int NUM_FU    = 4;
  localparam int IDX_W     = 4;

  logic CLK;
  logic nRST;
  int   tests_run    = 0;
  int   tests_failed = 0;

  completion_buffer_if #(.NUM_ENTRY(NUM_ENTRY), .NUM_FU(NUM_FU), .IDX_W(IDX_W)) cb_if ();

  completion_buffer #(.NUM_ENTRY(NUM_ENTRY), .NUM_FU(NUM_FU), .IDX_W(IDX_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .cb   (cb_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    cb_if.alloc_req    = 1'b0;
    cb_if.alloc_rd     = '0;
    cb_if.alloc_wen    = 1'b0;
    cb_if.wb_valid     = '0;
    cb_if.wb_index     = '0;
    cb_if.wb_data      = '0;
    cb_if.wb_exception = '0;
    cb_if.flush        = 1'b0;
  endtask

  task automatic set_wb(input int port, input int idx, input logic [31:0] data,
                        input logic exc);
    cb_if.wb_valid[port]     = 1'b1;
    cb_if.wb_index[port]     = IDX_W'(idx);
    cb_if.wb_data[port]      = data;
    cb_if.wb_exception[port] = exc;
  endtask

  task automatic alloc_burst(input int n, input int first_rd);
    for (int k = 0; k < n; k++) begin
      cb_if.alloc_req = 1'b1;
      cb_if.alloc_rd  = 5'(first_rd + k);
      cb_if.alloc_wen = 1'b1;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    logic [31:0] drain_data [4];
    drain_data = '{32'h1002, 32'h1003, 32'h1004, 32'hAAAA};

    nRST = 1'b0;
    idle_inputs();
    #3;
    check_output("reset_empty",        cb_if.empty,        1);
    check_output("reset_full",         cb_if.full,         0);
    check_output("reset_commit_valid", cb_if.commit_valid, 0);
    check_output("reset_alloc_ready",  cb_if.alloc_ready,  1);
    check_output("reset_alloc_index",  cb_if.alloc_index,  0);
    check_output("reset_count",        cb_if.count,        0);
    #9 nRST = 1'b1;
    tick();

    // Fill all 16 entries with no writebacks; the tail wraps back to index 0.
    for (int k = 0; k < 16; k++) begin
      cb_if.alloc_req = 1'b1;
      cb_if.alloc_rd  = 5'(k);
      cb_if.alloc_wen = 1'b1;
      #1;
      check_output("fill_alloc_index", cb_if.alloc_index, 32'(k));
      tick();
    end
    idle_inputs();
    #1;
    check_output("fill_full",         cb_if.full,         1);
    check_output("fill_alloc_ready",  cb_if.alloc_ready,  0);
    check_output("fill_count",        cb_if.count,        16);
    check_output("fill_alloc_index",  cb_if.alloc_index,  0);
    check_output("fill_commit_valid", cb_if.commit_valid, 0);

    // Full buffer, head completes while alloc_req is held high.
    set_wb(0, 0, 32'h100, 1'b0);
    cb_if.alloc_req = 1'b1;
    cb_if.alloc_rd  = 5'd15;
    cb_if.alloc_wen = 1'b1;
    #1;
    check_output("full_wb_alloc_ready", cb_if.alloc_ready, 0);
    tick();
    cb_if.wb_valid = '0;
    #1;
    check_output("full_commit_valid", cb_if.commit_valid, 1);
    check_output("full_commit_rd",    cb_if.commit_rd,    0);
    check_output("full_commit_data",  cb_if.commit_data,  32'h100);
    check_output("full_alloc_refused", cb_if.alloc_ready, 0);
    tick();
    #1;
    check_output("after_commit_count", cb_if.count,       15);
    check_output("after_commit_ready", cb_if.alloc_ready, 1);
    check_output("after_commit_index", cb_if.alloc_index, 0);
    tick();
    cb_if.alloc_req = 1'b0;
    #1;
    check_output("refill_count", cb_if.count, 16);
    check_output("refill_full",  cb_if.full,  1);

    cb_if.flush = 1'b1;
    #1;
    check_output("flush_alloc_ready", cb_if.alloc_ready, 0);
    tick();
    cb_if.flush = 1'b0;
    #1;
    check_output("flush1_empty", cb_if.empty,       1);
    check_output("flush1_count", cb_if.count,       0);
    check_output("flush1_index", cb_if.alloc_index, 0);

    // Three entries completed out of order (2, 0, 1) must retire in order.
    alloc_burst(3, 1);
    set_wb(1, 2, 32'h22, 1'b1);
    #1;
    check_output("ooo_c0_commit_valid", cb_if.commit_valid, 0);
    tick();
    idle_inputs();
    set_wb(0, 0, 32'h20, 1'b0);
    #1;
    check_output("ooo_c1_commit_valid", cb_if.commit_valid, 0);
    tick();
    idle_inputs();
    set_wb(2, 1, 32'h21, 1'b0);
    #1;
    check_output("ooo_c2_commit_valid", cb_if.commit_valid,     1);
    check_output("ooo_c2_commit_rd",    cb_if.commit_rd,        1);
    check_output("ooo_c2_commit_data",  cb_if.commit_data,      32'h20);
    check_output("ooo_c2_commit_exc",   cb_if.commit_exception, 0);
    tick();
    idle_inputs();
    #1;
    check_output("ooo_c3_commit_valid", cb_if.commit_valid, 1);
    check_output("ooo_c3_commit_rd",    cb_if.commit_rd,    2);
    check_output("ooo_c3_commit_data",  cb_if.commit_data,  32'h21);
    tick();
    #1;
    check_output("ooo_c4_commit_valid", cb_if.commit_valid,     1);
    check_output("ooo_c4_commit_rd",    cb_if.commit_rd,        3);
    check_output("ooo_c4_commit_data",  cb_if.commit_data,      32'h22);
    check_output("ooo_c4_commit_exc",   cb_if.commit_exception, 1);
    check_output("ooo_c4_commit_wen",   cb_if.commit_wen,       1);
    tick();
    #1;
    check_output("ooo_c5_commit_valid", cb_if.commit_valid, 0);
    check_output("ooo_c5_empty",        cb_if.empty,        1);
    check_output("ooo_c5_alloc_index",  cb_if.alloc_index,  3);

    // Entries 3..7 pending, then flush alongside an alloc and a writeback.
    alloc_burst(5, 10);
    #1;
    check_output("pre_flush_count", cb_if.count, 5);
    cb_if.flush     = 1'b1;
    cb_if.alloc_req = 1'b1;
    cb_if.alloc_rd  = 5'd20;
    set_wb(0, 3, 32'hDEAD, 1'b0);
    #1;
    check_output("flush2_commit_valid", cb_if.commit_valid, 0);
    tick();
    idle_inputs();
    #1;
    check_output("flush2_empty",        cb_if.empty,        1);
    check_output("flush2_count",        cb_if.count,        0);
    check_output("flush2_commit_valid", cb_if.commit_valid, 0);
    check_output("flush2_alloc_index",  cb_if.alloc_index,  0);

    // Entries 0..5; ports 0 and 3 collide on entry 5 and port 0 must win.
    alloc_burst(6, 0);
    #1;
    check_output("prio_count", cb_if.count, 6);
    set_wb(0, 0, 32'h1000, 1'b0);
    set_wb(1, 1, 32'h1001, 1'b0);
    set_wb(2, 2, 32'h1002, 1'b0);
    set_wb(3, 3, 32'h1003, 1'b0);
    tick();
    idle_inputs();
    set_wb(0, 5, 32'hAAAA, 1'b0);
    set_wb(3, 5, 32'hBBBB, 1'b0);
    set_wb(1, 4, 32'h1004, 1'b0);
    #1;
    check_output("prio_b_commit_valid", cb_if.commit_valid, 1);
    check_output("prio_b_commit_rd",    cb_if.commit_rd,    0);
    check_output("prio_b_commit_data",  cb_if.commit_data,  32'h1000);
    tick();
    idle_inputs();
    set_wb(2, 5, 32'hCCCC, 1'b0);
    #1;
    check_output("prio_c_commit_data", cb_if.commit_data, 32'h1001);
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      #1;
      check_output("prio_drain_valid", cb_if.commit_valid, 1);
      check_output("prio_drain_rd",    cb_if.commit_rd,    32'(k + 2));
      check_output("prio_drain_data",  cb_if.commit_data,  drain_data[k]);
      tick();
    end
    #1;
    check_output("prio_end_commit_valid", cb_if.commit_valid, 0);
    check_output("prio_end_empty",        cb_if.empty,        1);

    // Asynchronous reset between edges with five entries pending.
    alloc_burst(5, 1);
    #1;
    check_output("areset_pre_count", cb_if.count,       5);
    check_output("areset_pre_index", cb_if.alloc_index, 11);
    #1 nRST = 1'b0;
    #1;
    check_output("areset_empty",        cb_if.empty,        1);
    check_output("areset_count",        cb_if.count,        0);
    check_output("areset_full",         cb_if.full,         0);
    check_output("areset_alloc_ready",  cb_if.alloc_ready,  1);
    check_output("areset_alloc_index",  cb_if.alloc_index,  0);
    check_output("areset_commit_valid", cb_if.commit_valid, 0);
    #2 nRST = 1'b1;
    tick();
    #1;
    check_output("post_reset_empty", cb_if.empty,       1);
    check_output("post_reset_index", cb_if.alloc_index, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/completion_buffer.md
COMPLETION_BUFFER -- requirements
Module: completion_buffer

Interface
REQ-001 The parameter NUM_ENTRY SHALL default to NUM_CB_ENTRY (16) and set the buffer depth; it SHALL be a power of two and at least 2.
REQ-002 The parameter NUM_FU SHALL default to 4 and set the number of functional-unit writeback ports (arith, mul, div, loadstore).
REQ-003 The parameter IDX_W SHALL default to $clog2(NUM_ENTRY) and set the entry index width.
REQ-004 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 nRST  input  1  reset, asynchronous and active-low.
REQ-006 alloc_req  input  1  decode requests a new entry.
REQ-007 alloc_rd  input  5  destination register of the allocating instruction.
REQ-008 alloc_wen  input  1  the allocating instruction writes the register file.
REQ-009 alloc_ready  output  1  buffer can accept an allocation this cycle.
REQ-010 alloc_index  output  IDX_W  index granted to the allocation (tail pointer).
REQ-011 wb_valid  input  NUM_FU  per-port writeback strobe.
REQ-012 wb_index  input  NUM_FU x IDX_W  per-port target entry.
REQ-013 wb_data  input  NUM_FU x 32  per-port result word.
REQ-014 wb_exception  input  NUM_FU  per-port exception flag.
REQ-015 commit_valid  output  1  head entry is complete and retires this cycle.
REQ-016 commit_rd, commit_wen, commit_data, commit_exception  output  5/1/32/1  fields of the retiring entry.
REQ-017 flush  input  1  discard all entries.
REQ-018 full, empty  output  1 each  occupancy status.
REQ-019 count  output  IDX_W+1  number of allocated entries.

Function
REQ-020 Head and tail pointers SHALL be IDX_W+1 bits wide; the MSB is a wrap bit, full = (indices equal, wrap bits differ), empty = pointers equal.
REQ-021 alloc_ready SHALL equal !full && !flush, computed from registered state only, with no same-cycle commit bypass.
REQ-022 alloc_req && alloc_ready SHALL write {valid=1, done=0, rd, wen} at the tail entry and increment tail, visible next cycle.
REQ-023 A writeback with wb_valid[i] set to an entry whose valid bit is 1 and done bit is 0 SHALL set done, data and exception; writebacks to any other entry SHALL be ignored.
REQ-024 If several ports target the same entry in one cycle, the lowest-numbered port SHALL win.
REQ-025 commit_valid SHALL be asserted combinationally when the head entry is valid, the head entry is done and flush is low; the commit_* fields SHALL come from the head entry.
REQ-026 On commit, the head entry SHALL be cleared and head incremented; at most one commit SHALL occur per cycle.
REQ-027 Writeback-to-commit latency SHALL be exactly 1 cycle; a writeback to the head entry in cycle t commits in cycle t+1.
REQ-028 Simultaneous alloc and commit SHALL leave count unchanged; count SHALL be updated as count + alloc - commit.
REQ-029 Pointers SHALL wrap modulo 2*NUM_ENTRY without loss of ordering.
REQ-030 flush SHALL take priority over every other event: allocations, writebacks and commits in the flush cycle are discarded, all valid and done bits are cleared, head = tail = 0 and count = 0 from the next cycle.
REQ-031 commit_exception SHALL be passed through only; the surrounding pipeline drives flush in response.

Reset
REQ-032 While nRST is low, all valid and done bits, head, tail and count SHALL be 0; empty = 1, full = 0, commit_valid = 0, alloc_ready = 1, alloc_index = 0.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-034 The cb_entry_t struct (valid, done, rd, wen, data, exception) and cb_index_t SHALL be defined in rv32i_types_pkg; NUM_CB_ENTRY SHALL remain the shared depth constant.
REQ-035 The block SHALL be a single module with no sub-module; the writeback merge SHALL be a generate loop over NUM_FU.

Verification
REQ-036 Reset, then 16 allocs with no writebacks -> full = 1, alloc_ready = 0, count = 16, alloc_index returns to 0.
REQ-037 Alloc entries 0,1,2; writeback 2 then 0 then 1 -> commits occur in order 0,1,2, each 1 cycle after entry 0's and then entry 1's writeback.
REQ-038 Ports 0 and 3 both write index 5 (data 0xAAAA and 0xBBBB) in the same cycle -> committed data = 0xAAAA.
REQ-039 Buffer full with the head done, alloc_req held high -> commit occurs and the alloc is refused that cycle; the alloc is accepted next cycle and count stays 16.
REQ-040 Entries 3-7 allocated, flush together with an alloc and a writeback -> next cycle empty = 1, count = 0, no commit; the next alloc gets index 0.
REQ-041 nRST pulsed low asynchronously between clock edges with 5 entries pending -> outputs return to reset values before the next edge.
